alu_arbiter: RTL and testbench

- Shares one combinational 4-bit ALU (inputs `a[3:0]`, `b[3:0]`, `sel[1:0]`; output `out[7:0]`) among `NUM_REQ` requesters.
- Each requester presents operands and an opcode over a valid/ready handshake.
- The arbiter grants one requester at a time, drives the ALU from registered operands, captures the result, and returns it with the winner's ID on a shared response channel.
- It sits between the requesting blocks and the `alu` instance; the `alu` itself is unchanged.

---
 rtl/alu_arb_pkg.sv | 15 +
 rtl/alu_arbiter_if.sv | 34 +++
 rtl/alu_arbiter_rr_pick.sv | 37 +++
 rtl/alu_arbiter.sv | 118 +++++++++++
 tb/tb_alu_arbiter.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and widths for the ALU arbiter: FSM state encoding and the
// operand/opcode/result widths of the shared 4-bit ALU.
package alu_arb_pkg;

  localparam int ALU_IN_W  = 4;
  localparam int ALU_SEL_W = 2;
  localparam int ALU_OUT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } alu_arb_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of requester, ALU and response signals around the arbiter.
// slave = arbiter side, master = requesters / ALU / result consumer side.
interface alu_arbiter_if
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*ALU_IN_W-1:0]  req_a;
  logic [NUM_REQ*ALU_IN_W-1:0]  req_b;
  logic [NUM_REQ*ALU_SEL_W-1:0] req_sel;
  logic [ALU_IN_W-1:0]          alu_a;
  logic [ALU_IN_W-1:0]          alu_b;
  logic [ALU_SEL_W-1:0]         alu_sel;
  logic [ALU_OUT_W-1:0]         alu_out;
  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [ALU_OUT_W-1:0]         rsp_data;
  logic [ID_W-1:0]              rsp_id;

  modport slave (
    input  req_valid, req_a, req_b, req_sel, alu_out, rsp_ready,
    output req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_id
  );

  modport master (
    output req_valid, req_a, req_b, req_sel, alu_out, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_id
  );

endinterface

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set bit of req_i at or after
// ptr_i (wrapping), returned one-hot and encoded. ptr_i=0 gives fixed priority.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [IDX_W:0] pos;
  logic           found;

  // NOTE: every output and temporary gets a default before the loop so no
  // path leaves a value unassigned, which would infer a latch.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr_i} + (IDX_W + 1)'(k);
      if (pos >= (IDX_W + 1)'(N)) pos = pos - (IDX_W + 1)'(N);
      if (!found && req_i[pos[IDX_W-1:0]]) begin
        found                  = 1'b1;
        gnt_o[pos[IDX_W-1:0]] = 1'b1;
        idx_o                  = pos[IDX_W-1:0];
      end
    end
  end

  assign any_o = found;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NUM_REQ valid/ready requesters.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise fixed priority.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input logic          clk,
  input logic          rst_n,
  alu_arbiter_if.slave bus
);

  alu_arb_state_t       state_q, state_d;
  logic [ALU_IN_W-1:0]  a_q, a_d, b_q, b_d;
  logic [ALU_SEL_W-1:0] sel_q, sel_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [ALU_OUT_W-1:0] data_q, data_d;

  logic [ID_W-1:0]      ptr;
  logic [NUM_REQ-1:0]   pick_gnt;
  logic [ID_W-1:0]      pick_idx;
  logic                 pick_any;
  logic                 grant;

  logic [ALU_IN_W-1:0]  a_arr   [NUM_REQ];
  logic [ALU_IN_W-1:0]  b_arr   [NUM_REQ];
  logic [ALU_SEL_W-1:0] sel_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i]   = bus.req_a[i*ALU_IN_W +: ALU_IN_W];
    assign b_arr[i]   = bus.req_b[i*ALU_IN_W +: ALU_IN_W];
    assign sel_arr[i] = bus.req_sel[i*ALU_SEL_W +: ALU_SEL_W];
  end

`ifdef ALU_ARB_RR_EN
  logic [ID_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (grant) ptr_d = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  rr_pick #(.N(NUM_REQ), .IDX_W(ID_W)) u_pick (
    .req_i (bus.req_valid),
    .ptr_i (ptr),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Gated by rst_n so nothing is accepted while reset is held.
  assign grant = rst_n && (state_q == IDLE) && pick_any;

  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    sel_d         = sel_q;
    id_d          = id_q;
    data_d        = data_q;
    bus.req_ready = '0;
    case (state_q)
      IDLE: if (grant) begin
        bus.req_ready = pick_gnt;
        a_d           = a_arr[pick_idx];
        b_d           = b_arr[pick_idx];
        sel_d         = sel_arr[pick_idx];
        id_d          = pick_idx;
        state_d       = EXEC;
      end
      EXEC: begin
        data_d  = bus.alu_out;
        state_d = RESP;
      end
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge value; reset is synchronous, so it lives inside the clocked branch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      id_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      id_q    <= id_d;
      data_q  <= data_d;
    end
  end

  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_sel   = sel_q;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = data_q;
  assign bus.rsp_id    = id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a local 4-bit ALU
// (sel 0 add, 1 sub, 2 mul, 3 and).
module tb_alu_arbiter;

  localparam int NR = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  alu_arbiter_if #(.NUM_REQ(NR)) bus ();

  alu_arbiter #(.NUM_REQ(NR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_model(logic [3:0] a, logic [3:0] b, logic [1:0] s);
    case (s)
      2'd0:    return {4'h0, a} + {4'h0, b};
      2'd1:    return {4'h0, a} - {4'h0, b};
      2'd2:    return {4'h0, a} * {4'h0, b};
      default: return {4'h0, a & b};
    endcase
  endfunction

  assign bus.alu_out = alu_model(bus.alu_a, bus.alu_b, bus.alu_sel);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
    bus.req_a[4*i +: 4]   = a;
    bus.req_b[4*i +: 4]   = b;
    bus.req_sel[2*i +: 2] = s;
  endtask

  // Called right after a negedge; returns the first non-zero req_ready and
  // the number of extra cycles it took.
  task automatic wait_grant(output logic [3:0] g, output int cyc);
    cyc = 0;
    #1;
    while (bus.req_ready == '0 && cyc < 20) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    g = bus.req_ready;
  endtask

  // One isolated operation with rsp_ready high; checks grant, EXEC and RESP.
  task automatic run_op(input int i, input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] s, input logic [7:0] exp_d);
    logic [3:0] g;
    int         cyc;
    @(negedge clk);
    set_op(i, a, b, s);
    bus.req_valid[i] = 1'b1;
    wait_grant(g, cyc);
    check("op_grant", g, 4'b1 << i);
    @(negedge clk);
    bus.req_valid[i] = 1'b0;
    check("op_exec_alu_a", bus.alu_a, a);
    check("op_exec_alu_b", bus.alu_b, b);
    check("op_exec_alu_sel", bus.alu_sel, s);
    check("op_exec_rsp_valid", bus.rsp_valid, 0);
    @(negedge clk);
    check("op_rsp_valid", bus.rsp_valid, 1);
    check("op_rsp_data", bus.rsp_data, exp_d);
    check("op_rsp_id", bus.rsp_id, i);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, bus.req_ready, 0);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check({tag, "_alu_a"}, bus.alu_a, 0);
    check({tag, "_alu_b"}, bus.alu_b, 0);
    check({tag, "_alu_sel"}, bus.alu_sel, 0);
    check({tag, "_rsp_data"}, bus.rsp_data, 0);
    check({tag, "_rsp_id"}, bus.rsp_id, 0);
  endtask

  // Operands per requester for contention: 1+2, 3+4, 5-2, 4*3.
  logic [3:0] ca [NR] = '{4'h1, 4'h3, 4'h5, 4'h4};
  logic [3:0] cb [NR] = '{4'h2, 4'h4, 4'h2, 4'h3};
  logic [1:0] cs [NR] = '{2'd0, 2'd0, 2'd1, 2'd2};
  logic [7:0] cd [NR] = '{8'h03, 8'h07, 8'h03, 8'h0c};

  initial begin
    logic [3:0] g;
    int         cyc;
    int         exp_w;

    // Reset held 3 cycles with every requester asking
    rst_n         = 1'b0;
    bus.rsp_ready = 1'b1;
    bus.req_valid = '1;
    bus.req_a     = 16'h5a5a;
    bus.req_b     = 16'h3c3c;
    bus.req_sel   = 8'he4;
    repeat (3) begin
      @(negedge clk);
      #1;
      check_reset_outputs("reset");
    end
    bus.req_valid = '0;
    rst_n         = 1'b1;

    // Single requester, a=0 b=f through all opcodes, plus one nonzero product
    run_op(0, 4'h0, 4'hf, 2'd0, 8'h0f);
    run_op(0, 4'h0, 4'hf, 2'd1, 8'hf1);
    run_op(0, 4'h0, 4'hf, 2'd2, 8'h00);
    run_op(0, 4'h0, 4'hf, 2'd3, 8'h00);
    run_op(0, 4'h9, 4'h7, 2'd2, 8'h3f);

    // Fresh reset so the pointer starts at 0
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NR; i++) set_op(i, ca[i], cb[i], cs[i]);
`ifdef ALU_ARB_RR_EN
    bus.req_valid = 4'hf;
    for (int k = 0; k < 8; k++) begin
      exp_w = k % NR;
      wait_grant(g, cyc);
      check("rr_grant", g, 4'b1 << exp_w);
      check("rr_gap", cyc, (k == 0) ? 0 : 1);
      @(negedge clk);
      @(negedge clk);
      check("rr_rsp_id", bus.rsp_id, exp_w);
      check("rr_rsp_data", bus.rsp_data, cd[exp_w]);
    end
`else
    bus.req_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      exp_w = (k < 3) ? 1 : 3;
      wait_grant(g, cyc);
      check("fp_grant", g, 4'b1 << exp_w);
      @(negedge clk);
      @(negedge clk);
      check("fp_rsp_id", bus.rsp_id, exp_w);
      check("fp_rsp_data", bus.rsp_data, cd[exp_w]);
      if (k == 2) bus.req_valid[1] = 1'b0;
    end
`endif
    @(negedge clk);
    bus.req_valid = '0;

    // Back-pressure: requester 2 computes 6-10, result held while rsp_ready=0
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    set_op(2, 4'h6, 4'ha, 2'd1);
    bus.req_valid[2] = 1'b1;
    wait_grant(g, cyc);
    check("bp_grant", g, 4'b0100);
    @(negedge clk);
    bus.req_valid = 4'b0001;
    set_op(0, 4'h2, 4'h3, 2'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      check("bp_rsp_valid", bus.rsp_valid, 1);
      check("bp_rsp_data", bus.rsp_data, 8'hfc);
      check("bp_rsp_id", bus.rsp_id, 2);
      check("bp_req_ready", bus.req_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_release_rsp_valid", bus.rsp_valid, 0);
    check("bp_release_idle_grant", bus.req_ready, 4'b0001);
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    check("bp_next_rsp_data", bus.rsp_data, 8'h05);

    // Reset during EXEC after granting requester 1
    @(negedge clk);
    set_op(1, 4'h7, 4'h8, 2'd0);
    bus.req_valid[1] = 1'b1;
    wait_grant(g, cyc);
    check("rx_grant", g, 4'b0010);
    @(negedge clk);
    bus.req_valid = '0;
    check("rx_in_exec_alu_a", bus.alu_a, 4'h7);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check_reset_outputs("rx_reset");
    @(negedge clk);
    check("rx_no_pulse", bus.rsp_valid, 0);
    rst_n = 1'b1;
    bus.req_valid = 4'hf;
    #1;
    check("rx_ptr_zero_grant", bus.req_ready, 4'b0001);
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    check("rx_after_rsp_id", bus.rsp_id, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
